// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, 3-sample majority vote, runtime frame format,
// break/overrun/false-start handling and a show-ahead receive FIFO with valid/ready drain.
module uart_rx_fifo #(
    parameter int  DIV_W      = 16,
    parameter int  FIFO_DEPTH = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_in,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       data_bits,
    input  logic [1:0]       parity_type,
    input  logic             stop_bits,
    output logic [7:0]       m_data,
    output logic [2:0]       m_err,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             active_flag,
    output logic             frame_done,
    output logic             overrun_flag,
    input  logic             clr_overrun,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Odd expects data^parity == 1, even expects 0; other codes carry no parity bit.
    function automatic logic parity_error(input logic [7:0] data, input logic pbit,
                                          input logic [1:0] ptype);
        logic err;
        case (ptype)
            2'b01:   err = ~(^data ^ pbit);
            2'b10:   err = ^data ^ pbit;
            default: err = 1'b0;
        endcase
        return err;
    endfunction

    logic             rx_meta_r, rxs_r, rxs_prev_r;
    logic [DIV_W-1:0] tick_cnt_r;
    logic [3:0]       samp_cnt_r;
    logic             samp7_r, samp8_r;
    state_t           state_r, state_next;
    logic [7:0]       shift_r, shift_next;
    logic [2:0]       bit_idx_r, bit_idx_next;
    logic [1:0]       nbits_r, nbits_next;
    logic [1:0]       ptype_r, ptype_next;
    logic             stop2_r, stop2_next;
    logic             pbit_r, pbit_next;
    logic             stop1_r, stop1_next;
    logic             second_r, second_next;
    logic             push_r, push_next;
    logic [10:0]      word_r, word_next;
    logic             active_r;

    logic [DIV_W-1:0] div_eff_s;
    logic             tick_s, at_mid_s, at_end_s, maj_s, par_en_s;
    logic [7:0]       aligned_s;
    logic             perr_s, ferr_s, brk_s;
    logic [2:0]       last_idx_s;

    assign div_eff_s  = (baud_div == DIV_ZERO) ? DIV_ONE : baud_div;
    assign tick_s     = (state_r != IDLE) && (tick_cnt_r == div_eff_s);
    assign at_mid_s   = tick_s && (samp_cnt_r == 4'd9);
    assign at_end_s   = tick_s && (samp_cnt_r == 4'd15);
    assign maj_s      = majority3(samp7_r, samp8_r, rxs_r);
    assign par_en_s   = (ptype_r == 2'b01) || (ptype_r == 2'b10);
    assign last_idx_s = 3'd4 + {1'b0, nbits_r};
    assign aligned_s  = shift_r >> (2'd3 - nbits_r);
    assign perr_s     = parity_error(aligned_s, pbit_r, ptype_r);
    // maj_s is the last stop sample whenever these are consumed.
    assign ferr_s     = ~maj_s | (stop2_r & ~stop1_r);
    assign brk_s      = (aligned_s == 8'd0) && (!par_en_s || !pbit_r) && !maj_s
                        && (!stop2_r || !stop1_r);

    // Two-flop synchroniser plus previous-value flop for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r  <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            rx_meta_r  <= rx_in;
            rxs_r      <= rx_meta_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // Oversample tick divider and per-bit tick index; both parked at zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_r <= DIV_ZERO;
            samp_cnt_r <= 4'd0;
        end else if (state_r == IDLE) begin
            tick_cnt_r <= DIV_ZERO;
            samp_cnt_r <= 4'd0;
        end else if (tick_s) begin
            tick_cnt_r <= DIV_ZERO;
            samp_cnt_r <= samp_cnt_r + 4'd1;
        end else begin
            tick_cnt_r <= tick_cnt_r + DIV_ONE;
        end
    end

    // Capture the first two of the three majority samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp7_r <= 1'b1;
            samp8_r <= 1'b1;
        end else begin
            if (tick_s && samp_cnt_r == 4'd7) samp7_r <= rxs_r;
            if (tick_s && samp_cnt_r == 4'd8) samp8_r <= rxs_r;
        end
    end

    // Receiver FSM next-state and datapath.
    always_comb begin
        state_next   = state_r;
        shift_next   = shift_r;
        bit_idx_next = bit_idx_r;
        nbits_next   = nbits_r;
        ptype_next   = ptype_r;
        stop2_next   = stop2_r;
        pbit_next    = pbit_r;
        stop1_next   = stop1_r;
        second_next  = second_r;
        push_next    = 1'b0;
        word_next    = word_r;
        case (state_r)
            IDLE: begin
                if (rxs_prev_r && !rxs_r) begin
                    state_next   = START;
                    nbits_next   = data_bits;
                    ptype_next   = parity_type;
                    stop2_next   = stop_bits;
                    bit_idx_next = 3'd0;
                    shift_next   = 8'd0;
                    second_next  = 1'b0;
                    pbit_next    = 1'b0;
                    stop1_next   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (at_mid_s && maj_s) begin
                    state_next = IDLE;
                end else if (at_end_s) begin
                    state_next = DATA;
                end else begin
                    state_next = START;
                end
            end
            DATA: begin
                if (at_mid_s) begin
                    shift_next = {maj_s, shift_r[7:1]};
                end else if (at_end_s) begin
                    if (bit_idx_r == last_idx_s) begin
                        bit_idx_next = 3'd0;
                        state_next   = par_en_s ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_next = DATA;
                end
            end
            PARITY: begin
                if (at_mid_s) begin
                    pbit_next = maj_s;
                end else if (at_end_s) begin
                    state_next = STOP;
                end else begin
                    state_next = PARITY;
                end
            end
            STOP: begin
                if (at_mid_s) begin
                    if (stop2_r && !second_r) begin
                        stop1_next = maj_s;
                    end else begin
                        push_next  = 1'b1;
                        word_next  = {perr_s, ferr_s, brk_s, aligned_s};
                        state_next = maj_s ? IDLE : WAIT_HIGH;
                    end
                end else if (at_end_s) begin
                    second_next = 1'b1;
                end else begin
                    state_next = STOP;
                end
            end
            WAIT_HIGH: begin
                if (rxs_r) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_HIGH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Receiver FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            shift_r   <= 8'd0;
            bit_idx_r <= 3'd0;
            nbits_r   <= 2'd0;
            ptype_r   <= 2'd0;
            stop2_r   <= 1'b0;
            pbit_r    <= 1'b0;
            stop1_r   <= 1'b1;
            second_r  <= 1'b0;
            push_r    <= 1'b0;
            word_r    <= 11'd0;
            active_r  <= 1'b0;
        end else begin
            state_r   <= state_next;
            shift_r   <= shift_next;
            bit_idx_r <= bit_idx_next;
            nbits_r   <= nbits_next;
            ptype_r   <= ptype_next;
            stop2_r   <= stop2_next;
            pbit_r    <= pbit_next;
            stop1_r   <= stop1_next;
            second_r  <= second_next;
            push_r    <= push_next;
            word_r    <= word_next;
            active_r  <= (state_next != IDLE);
        end
    end

    logic [10:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, rd_next_s;
    logic [CNT_W-1:0] count_r, count_next_s;
    logic             m_valid_r, ovr_r;
    logic [7:0]       m_data_r;
    logic [2:0]       m_err_r;
    logic             pop_s, full_s, wr_en_s, ovr_set_s;
    logic [10:0]      head_s;

    assign pop_s     = m_valid_r && m_ready;
    assign full_s    = (count_r == CNT_FULL);
    assign wr_en_s   = push_r && (!full_s || pop_s);
    assign ovr_set_s = push_r && full_s && !pop_s;
    assign rd_next_s = pop_s ? rd_ptr_r + PTR_ONE : rd_ptr_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Head word after this cycle; bypasses the write when it becomes the only entry.
    always_comb begin
        head_s = 11'd0;
        if (wr_en_s && count_next_s == CNT_ONE) begin
            head_s = word_r;
        end else if (count_next_s == CNT_ZERO) begin
            head_s = 11'd0;
        end else begin
            head_s = mem_r[rd_next_s];
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (wr_en_s) mem_r[wr_ptr_r] <= word_r;
    end

    // FIFO pointers, count, registered show-ahead outputs and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= CNT_ZERO;
            m_valid_r <= 1'b0;
            m_data_r  <= 8'd0;
            m_err_r   <= 3'd0;
            ovr_r     <= 1'b0;
        end else begin
            if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            rd_ptr_r  <= rd_next_s;
            count_r   <= count_next_s;
            m_valid_r <= (count_next_s != CNT_ZERO);
            m_data_r  <= head_s[7:0];
            m_err_r   <= head_s[10:8];
            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end else if (clr_overrun) begin
                ovr_r <= 1'b0;
            end else begin
                ovr_r <= ovr_r;
            end
        end
    end

    assign m_data       = m_data_r;
    assign m_err        = m_err_r;
    assign m_valid      = m_valid_r;
    assign active_flag  = active_r;
    assign frame_done   = push_r;
    assign overrun_flag = ovr_r;
    assign fifo_count   = count_r;

endmodule
